// File: rtl/parking_gate_ctrl_pkg.sv
// Shared types and constants for the parking gate controller.
// The slot index width fixes the addressable slot range at 16.
package parking_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } gate_state_t;

  localparam int NUM_SLOTS_DEF = 15;
  localparam int SLOT_W        = 4;

endpackage

// File: rtl/slot_alloc_penc.sv
// Lowest-clear-bit priority encoder over the occupancy vector.
// none_free is high when every slot is taken.
module slot_alloc_penc
  import parking_gate_ctrl_pkg::*;
#(
  parameter int N = NUM_SLOTS_DEF
) (
  input  logic [N-1:0]      cars,
  output logic [SLOT_W-1:0] idx,
  output logic              none_free
);

  always_comb begin
    idx       = '0;
    none_free = 1'b1;
    // Scan downwards so the lowest clear bit wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (!cars[i]) begin
        idx       = SLOT_W'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: edge-detected entry/exit requests,
// slot allocation, timed gate opening, status pulses.
module parking_gate_ctrl
  import parking_gate_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS   = NUM_SLOTS_DEF,
  parameter int GATE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic [NUM_SLOTS-1:0] cars,
  output logic [SLOT_W-1:0]    assigned_slot,
  output logic                 entry_ack,
  output logic                 entry_nack,
  output logic                 exit_ack,
  output logic                 err,
  output logic                 entry_gate,
  output logic                 exit_gate,
  output logic                 full
);

  localparam logic [7:0] CNT_LOAD = 8'(GATE_CYCLES - 1);

  gate_state_t state, state_n;

  logic                 entry_q, exit_q;
  logic                 entry_pend, exit_pend;
  logic                 entry_pend_n, exit_pend_n;
  logic [SLOT_W-1:0]    slot_q, slot_q_n;
  logic [7:0]           cnt, cnt_n;
  logic [NUM_SLOTS-1:0] cars_n;
  logic [SLOT_W-1:0]    aslot_n;
  logic                 eack_n, enack_n, xack_n, err_n;

  logic                 entry_rise, exit_rise;
  logic                 entry_go, exit_go;
  logic [SLOT_W-1:0]    eslot;
  logic [(1<<SLOT_W)-1:0] cars_ext;
  logic                 eslot_ok;
  logic [SLOT_W-1:0]    free_idx;
  logic                 none_free;

  slot_alloc_penc #(
    .N(NUM_SLOTS)
  ) u_penc (
    .cars      (cars),
    .idx       (free_idx),
    .none_free (none_free)
  );

  assign full       = &cars;
  assign entry_gate = (state == ENTRY_OPEN);
  assign exit_gate  = (state == EXIT_OPEN);

  assign entry_rise = entry_req & ~entry_q;
  assign exit_rise  = exit_req & ~exit_q;
  assign entry_go   = entry_pend | entry_rise;
  assign exit_go    = exit_pend | exit_rise;
  // A fresh edge in IDLE is served at once, using the live slot.
  assign eslot      = exit_pend ? slot_q : exit_slot;

  always_comb begin
    cars_ext                = '0;
    cars_ext[NUM_SLOTS-1:0] = cars;
    eslot_ok = (int'(eslot) < NUM_SLOTS) && cars_ext[eslot];
  end

  always_comb begin
    state_n      = state;
    cars_n       = cars;
    aslot_n      = assigned_slot;
    cnt_n        = cnt;
    eack_n       = 1'b0;
    enack_n      = 1'b0;
    xack_n       = 1'b0;
    err_n        = 1'b0;
    entry_pend_n = entry_go;
    exit_pend_n  = exit_go;
    slot_q_n     = (exit_rise && !exit_pend) ? exit_slot : slot_q;
    unique case (state)
      IDLE: begin
        if (exit_go) begin
          exit_pend_n = 1'b0;
          if (eslot_ok) begin
            cars_n  = cars & ~(NUM_SLOTS'(1) << eslot);
            xack_n  = 1'b1;
            state_n = EXIT_OPEN;
            cnt_n   = CNT_LOAD;
          end else begin
            err_n = 1'b1;
          end
        end else if (entry_go) begin
          entry_pend_n = 1'b0;
          if (none_free) begin
            enack_n = 1'b1;
          end else begin
            cars_n  = cars | (NUM_SLOTS'(1) << free_idx);
            aslot_n = free_idx;
            eack_n  = 1'b1;
            state_n = ENTRY_OPEN;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        if (cnt == 8'd0) state_n = IDLE;
        else             cnt_n   = cnt - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cars          <= '0;
      assigned_slot <= '0;
      cnt           <= '0;
      entry_q       <= 1'b0;
      exit_q        <= 1'b0;
      entry_pend    <= 1'b0;
      exit_pend     <= 1'b0;
      slot_q        <= '0;
      entry_ack     <= 1'b0;
      entry_nack    <= 1'b0;
      exit_ack      <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_n;
      cars          <= cars_n;
      assigned_slot <= aslot_n;
      cnt           <= cnt_n;
      entry_q       <= entry_req;
      exit_q        <= exit_req;
      entry_pend    <= entry_pend_n;
      exit_pend     <= exit_pend_n;
      slot_q        <= slot_q_n;
      entry_ack     <= eack_n;
      entry_nack    <= enack_n;
      exit_ack      <= xack_n;
      err           <= err_n;
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: vector table plus
// hand sequences for arbitration, held requests and reset.
module tb_parking_gate_ctrl;

  localparam int NS = 15;
  localparam int GC = 8;

  logic          clk;
  logic          rst;
  logic          entry_req;
  logic          exit_req;
  logic [3:0]    exit_slot;
  logic [NS-1:0] cars;
  logic [3:0]    assigned_slot;
  logic          entry_ack, entry_nack, exit_ack, err;
  logic          entry_gate, exit_gate, full;

  int nvec;
  int nfail;

  parking_gate_ctrl #(
    .NUM_SLOTS   (NS),
    .GATE_CYCLES (GC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .exit_slot     (exit_slot),
    .cars          (cars),
    .assigned_slot (assigned_slot),
    .entry_ack     (entry_ack),
    .entry_nack    (entry_nack),
    .exit_ack      (exit_ack),
    .err           (err),
    .entry_gate    (entry_gate),
    .exit_gate     (exit_gate),
    .full          (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         en;
    bit         ex;
    logic [3:0] slot;
    bit         eack;
    bit         nack;
    bit         xack;
    bit         err;
    logic [14:0] cars;
    logic [3:0] aslot;
    int         glen;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit en, bit ex, logic [3:0] slot,
                              bit eack, bit nack, bit xack, bit er,
                              logic [14:0] c, logic [3:0] a, int g);
    vec_t v;
    v.en = en; v.ex = ex; v.slot = slot;
    v.eack = eack; v.nack = nack; v.xack = xack; v.err = er;
    v.cars = c; v.aslot = a; v.glen = g;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gate(input string nm, input int exp_len);
    int n;
    n = 0;
    while ((entry_gate || exit_gate) && n < 40) begin
      n++;
      tick();
    end
    chk({nm, "_gate_len"}, n, exp_len);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    entry_req = 1'b0;
    exit_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int k);
    string nm;
    nm = $sformatf("v%0d", k);
    tick();
    entry_req = v.en;
    exit_req  = v.ex;
    exit_slot = v.slot;
    tick();
    chk({nm, "_entry_ack"}, entry_ack, v.eack);
    chk({nm, "_entry_nack"}, entry_nack, v.nack);
    chk({nm, "_exit_ack"}, exit_ack, v.xack);
    chk({nm, "_err"}, err, v.err);
    chk({nm, "_cars"}, cars, v.cars);
    chk({nm, "_aslot"}, assigned_slot, v.aslot);
    chk({nm, "_full"}, full, (v.cars == 15'h7FFF));
    chk({nm, "_entry_gate"}, entry_gate, v.eack);
    chk({nm, "_exit_gate"}, exit_gate, v.xack);
    entry_req = 1'b0;
    exit_req  = 1'b0;
    wait_gate(nm, v.glen);
    tick();
    chk({nm, "_pulses_clear"},
        {entry_ack, entry_nack, exit_ack, err}, 4'b0000);
  endtask

  initial begin
    logic [14:0] c;
    nvec = 0;
    nfail = 0;
    entry_req = 1'b0;
    exit_req = 1'b0;
    exit_slot = 4'd0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cars", cars, 15'h0);
    chk("rst_aslot", assigned_slot, 4'd0);
    chk("rst_pulses", {entry_ack, entry_nack, exit_ack, err}, 4'b0);
    chk("rst_gates", {entry_gate, exit_gate}, 2'b0);
    chk("rst_full", full, 1'b0);
    rst = 1'b0;

    tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 15'h0001, 0, GC));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 15'h0003, 1, GC));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 15'h0007, 2, GC));
    tv.push_back(mk(0, 1, 1, 0, 0, 1, 0, 15'h0005, 2, GC));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 15'h0007, 1, GC));
    tv.push_back(mk(0, 1, 15, 0, 0, 0, 1, 15'h0007, 1, 0));
    tv.push_back(mk(0, 1, 3, 0, 0, 0, 1, 15'h0007, 1, 0));
    for (int i = 3; i < NS; i++) begin
      c = 15'((32'd1 << (i + 1)) - 1);
      tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, c, 4'(i), GC));
    end
    tv.push_back(mk(1, 0, 0, 0, 1, 0, 0, 15'h7FFF, 14, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 1, 0, 15'h7FFE, 14, GC));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 15'h7FFF, 0, GC));
    tv.push_back(mk(0, 1, 7, 0, 0, 1, 0, 15'h7F7F, 0, GC));
    tv.push_back(mk(0, 1, 7, 0, 0, 0, 1, 15'h7F7F, 0, 0));

    foreach (tv[k]) apply(tv[k], k);

    // Simultaneous entry and exit: exit first, entry after gate.
    do_reset();
    apply(mk(1, 0, 0, 1, 0, 0, 0, 15'h0001, 0, GC), 100);
    tick();
    entry_req = 1'b1;
    exit_req  = 1'b1;
    exit_slot = 4'd0;
    tick();
    entry_req = 1'b0;
    exit_req  = 1'b0;
    chk("both_exit_ack", exit_ack, 1'b1);
    chk("both_entry_ack_early", entry_ack, 1'b0);
    chk("both_cars_exit", cars, 15'h0000);
    chk("both_exit_gate", exit_gate, 1'b1);
    wait_gate("both_exit", GC);
    tick();
    chk("both_entry_ack", entry_ack, 1'b1);
    chk("both_cars_entry", cars, 15'h0001);
    chk("both_aslot", assigned_slot, 4'd0);
    chk("both_entry_gate", entry_gate, 1'b1);
    wait_gate("both_entry", GC);

    // Holding entry_req high yields a single entry.
    tick();
    entry_req = 1'b1;
    tick();
    chk("hold_ack", entry_ack, 1'b1);
    chk("hold_cars", cars, 15'h0003);
    repeat (20) tick();
    chk("hold_cars_after", cars, 15'h0003);
    chk("hold_gate_closed", entry_gate, 1'b0);
    entry_req = 1'b0;

    // Reset during the third ENTRY_OPEN cycle.
    do_reset();
    tick();
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    chk("mid_ack", entry_ack, 1'b1);
    chk("mid_gate_open", entry_gate, 1'b1);
    tick();
    tick();
    exit_req  = 1'b1;
    exit_slot = 4'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exit_req = 1'b0;
    chk("mid_gate_closed", entry_gate, 1'b0);
    chk("mid_cars", cars, 15'h0);
    chk("mid_aslot", assigned_slot, 4'd0);
    tick();
    tick();
    chk("mid_no_pending", {exit_ack, err, exit_gate}, 3'b000);
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    chk("mid_idle_entry", {entry_ack, entry_gate}, 2'b11);
    chk("mid_idle_cars", cars, 15'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter NUM_SLOTS, default 15, SHALL set the number of parking slots and the width of the occupancy vector.
REQ-002 Parameter GATE_CYCLES, default 8, SHALL set the number of cycles a gate is held open (legal range 1..255).
REQ-003 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: SHALL be the reset; synchronous, active-high.
REQ-005 Port entry_req, input, 1: SHALL be the entry-sensor request, level, active-high.
REQ-006 Port exit_req, input, 1: SHALL be the exit-sensor request, level, active-high.
REQ-007 Port exit_slot, input, 4: SHALL be the slot index being vacated, valid while exit_req is high.
REQ-008 Port cars, output, NUM_SLOTS: SHALL be the occupancy vector, bit i = slot i occupied; it feeds the downstream occupancy counter and display.
REQ-009 Port assigned_slot, output, 4: SHALL be the slot index granted by the last accepted entry.
REQ-010 Ports entry_ack, entry_nack, exit_ack, err, output, 1 each: SHALL be single-cycle status pulses.
REQ-011 Ports entry_gate, exit_gate, output, 1 each: SHALL be the gate-open drives.
REQ-012 Port full, output, 1: SHALL be high exactly when all bits of cars are set.

Function
REQ-013 A request SHALL be the rising edge of entry_req or exit_req, detected against a registered copy; holding a request high SHALL NOT generate repeat requests.
REQ-014 Each detected edge SHALL set a pending flag; exit_slot SHALL be captured on the exit_req edge; a second edge while that flag is set SHALL be ignored.
REQ-015 The FSM SHALL have states IDLE, ENTRY_OPEN, EXIT_OPEN; pending requests SHALL be served only in IDLE.
REQ-016 In IDLE with both flags pending, exit SHALL be served first.
REQ-017 Entry served at edge t, not full: at t+1 state SHALL be ENTRY_OPEN, the lowest-index clear bit of cars SHALL be set, assigned_slot SHALL hold that index, entry_ack SHALL pulse, and the entry pending flag SHALL clear.
REQ-018 Entry served while full: entry_nack SHALL pulse at t+1, cars unchanged, state stays IDLE, flag clears.
REQ-019 Exit served at edge t with valid captured slot (index < NUM_SLOTS and bit set): at t+1 the bit SHALL clear, exit_ack SHALL pulse, and state SHALL be EXIT_OPEN.
REQ-020 Exit with invalid slot (index >= NUM_SLOTS or bit clear): err SHALL pulse at t+1, cars unchanged, state stays IDLE, flag clears.
REQ-021 entry_gate SHALL be high exactly during ENTRY_OPEN, exit_gate exactly during EXIT_OPEN; each open state SHALL last GATE_CYCLES cycles, then return to IDLE.
REQ-022 The gate counter SHALL be 8 bits, load GATE_CYCLES-1 on entry to an open state, and decrement to 0 without wrap.
REQ-023 full SHALL be combinational from cars; the occupied count SHALL never exceed NUM_SLOTS.

Reset
REQ-024 On rst: state IDLE, cars all zero, assigned_slot 0, all pulses and gates 0, pending flags and edge registers 0, counter 0.
REQ-025 Reset asserted mid-gate SHALL close the gate on the next edge and discard pending requests.

Structure
REQ-026 A shared package SHALL hold the state enum, NUM_SLOTS default and slot-index width constant.
REQ-027 One sub-module, slot_alloc_penc (lowest-clear-bit priority encoder with a none-free flag), SHALL be instantiated.

Verification
REQ-028 Reset, then entry_req edge -> entry_ack 1 cycle later, cars=0x0001, assigned_slot=0, entry_gate high 8 cycles.
REQ-029 15 entries with gates completed -> cars=0x7FFF, full=1; 16th entry -> entry_nack pulse, cars unchanged.
REQ-030 cars=0x0007, exit_slot=1 -> exit_ack, cars=0x0005; next entry -> assigned_slot=1, cars=0x0007.
REQ-031 Entry and exit edges in same cycle at cars=0x0001, exit_slot=0 -> exit served first (cars=0x0000), entry afterwards gives cars=0x0001.
REQ-032 exit_slot=15, or exit_slot=3 with bit 3 clear -> err pulse, no gate, cars unchanged.
REQ-033 rst during ENTRY_OPEN cycle 3 -> next cycle entry_gate=0, cars=0, state IDLE.
